// File: rtl/fft_pkg.sv
// Shared state encoding, width offsets and complex type for the butterfly datapath.
`ifndef FFT_CPLX_DW
`define FFT_CPLX_DW 8
`endif

package fft_pkg;

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, ADD, OUT} bfly_state_t;

  // Widths relative to DW: product 2*DW, twiddled term DW+2, sums DW+3.
  localparam int PROD_W_MUL  = 2;
  localparam int T_W_EXTRA   = 2;
  localparam int SUM_W_EXTRA = 3;

  typedef struct packed {
    logic signed [`FFT_CPLX_DW-1:0] re;
    logic signed [`FFT_CPLX_DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_bfly_resize.sv
// Combinational DW+3 -> DW resize with overflow detect.
// BFLY_SAT_EN selects clamping; otherwise the low DW bits are kept.
module fft_bfly_resize
  import fft_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW+SUM_W_EXTRA-1:0] din,
  output logic [DW-1:0]             dout,
  output logic                      ovf
);

  localparam int SW = DW + SUM_W_EXTRA;

  logic [SW-DW:0] head;

  always_comb begin
    // In range exactly when every bit from the DW-bit sign upward agrees.
    head = din[SW-1:DW-1];
    ovf  = !((&head) || !(|head));
`ifdef BFLY_SAT_EN
    if (!ovf) begin
      dout = din[DW-1:0];
    end else if (din[SW-1]) begin
      dout = {1'b1, {(DW-1){1'b0}}};
    end else begin
      dout = {1'b0, {(DW-1){1'b1}}};
    end
`else
    dout = din[DW-1:0];
`endif
  end

endmodule

// File: rtl/fft_bfly_seq.sv
// Handshaked radix-2 DIT butterfly, two time-shared multipliers, inverse and scale modes.
// Build option BFLY_SAT_EN makes the result resize saturate instead of wrap.
module fft_bfly_seq
  import fft_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inv,
  input  logic          in_scale,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [DW-1:0] w_re,
  input  logic [DW-1:0] w_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x0_re,
  output logic [DW-1:0] x0_im,
  output logic [DW-1:0] x1_re,
  output logic [DW-1:0] x1_im,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int PW = PROD_W_MUL * DW;
  localparam int TW = DW + T_W_EXTRA;
  localparam int SW = DW + SUM_W_EXTRA;

  bfly_state_t   state_q, state_d;
  logic [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
  logic [DW-1:0] a_re_d, a_im_d, b_re_d, b_im_d, w_re_d, w_im_d;
  logic          inv_q, inv_d, scale_q, scale_d;
  logic [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic [DW-1:0] x_q [4];
  logic [DW-1:0] x_d [4];
  logic          out_valid_q, out_valid_d, ovf_q, ovf_d;

  logic          accept;
  logic [DW-1:0] m0_w, m1_w;
  logic [PW-1:0] m0, m1;
  logic [PW:0]   tr_full, ti_full;
  logic [TW-1:0] t_re, t_im;
  logic [SW-1:0] a_re_x, a_im_x, t_re_x, t_im_x;
  logic [SW-1:0] s_raw [4];
  logic [SW-1:0] s_fin [4];
  logic [DW-1:0] r_val [4];
  logic [3:0]    r_ovf;
  logic          unused_lsb;

  // MUL1 forms br*wr / bi*wi, MUL2 forms br*wi / bi*wr on the same two multipliers.
  assign m0_w = (state_q == MUL1) ? w_re_q : w_im_q;
  assign m1_w = (state_q == MUL1) ? w_im_q : w_re_q;
  assign m0 = $signed({{DW{b_re_q[DW-1]}}, b_re_q}) * $signed({{DW{m0_w[DW-1]}}, m0_w});
  assign m1 = $signed({{DW{b_im_q[DW-1]}}, b_im_q}) * $signed({{DW{m1_w[DW-1]}}, m1_w});

  // Conjugation is folded into the add/sub so w_im = -2^(DW-1) stays exact.
  assign tr_full = inv_q ? ({p_rr_q[PW-1], p_rr_q} + {p_ii_q[PW-1], p_ii_q})
                         : ({p_rr_q[PW-1], p_rr_q} - {p_ii_q[PW-1], p_ii_q});
  assign ti_full = inv_q ? ({p_ir_q[PW-1], p_ir_q} - {p_ri_q[PW-1], p_ri_q})
                         : ({p_ri_q[PW-1], p_ri_q} + {p_ir_q[PW-1], p_ir_q});
  assign t_re = tr_full[PW:DW-1];
  assign t_im = ti_full[PW:DW-1];
  assign unused_lsb = ^{tr_full[DW-2:0], ti_full[DW-2:0]};

  assign a_re_x = {{(SW-DW){a_re_q[DW-1]}}, a_re_q};
  assign a_im_x = {{(SW-DW){a_im_q[DW-1]}}, a_im_q};
  assign t_re_x = {{(SW-TW){t_re[TW-1]}}, t_re};
  assign t_im_x = {{(SW-TW){t_im[TW-1]}}, t_im};
  assign s_raw[0] = a_re_x + t_re_x;
  assign s_raw[1] = a_im_x + t_im_x;
  assign s_raw[2] = a_re_x - t_re_x;
  assign s_raw[3] = a_im_x - t_im_x;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_res
      assign s_fin[gi] = scale_q ? {s_raw[gi][SW-1], s_raw[gi][SW-1:1]} : s_raw[gi];
      fft_bfly_resize #(.DW(DW)) u_resize (
        .din  (s_fin[gi]),
        .dout (r_val[gi]),
        .ovf  (r_ovf[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    b_re_d      = b_re_q;
    b_im_d      = b_im_q;
    w_re_d      = w_re_q;
    w_im_d      = w_im_q;
    inv_d       = inv_q;
    scale_d     = scale_q;
    p_rr_d      = p_rr_q;
    p_ii_d      = p_ii_q;
    p_ri_d      = p_ri_q;
    p_ir_d      = p_ir_q;
    out_valid_d = out_valid_q;
    for (int i = 0; i < 4; i++) x_d[i] = x_q[i];
    ovf_d       = ovf_q && !ovf_clr;
    in_ready    = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    accept      = in_valid && in_ready;

    case (state_q)
      IDLE: if (accept) state_d = MUL1;
      MUL1: begin
        p_rr_d  = m0;
        p_ii_d  = m1;
        state_d = MUL2;
      end
      MUL2: begin
        p_ri_d  = m0;
        p_ir_d  = m1;
        state_d = ADD;
      end
      ADD: begin
        for (int i = 0; i < 4; i++) x_d[i] = r_val[i];
        out_valid_d = 1'b1;
        if (|r_ovf) ovf_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? MUL1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_re_d  = a_re;
      a_im_d  = a_im;
      b_re_d  = b_re;
      b_im_d  = b_im;
      w_re_d  = w_re;
      w_im_d  = w_im;
      inv_d   = in_inv;
      scale_d = in_scale;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      w_re_q      <= '0;
      w_im_q      <= '0;
      inv_q       <= 1'b0;
      scale_q     <= 1'b0;
      p_rr_q      <= '0;
      p_ii_q      <= '0;
      p_ri_q      <= '0;
      p_ir_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      b_re_q      <= b_re_d;
      b_im_q      <= b_im_d;
      w_re_q      <= w_re_d;
      w_im_q      <= w_im_d;
      inv_q       <= inv_d;
      scale_q     <= scale_d;
      p_rr_q      <= p_rr_d;
      p_ii_q      <= p_ii_d;
      p_ri_q      <= p_ri_d;
      p_ir_q      <= p_ir_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < 4; i++) x_q[i] <= x_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign x0_re     = x_q[0];
  assign x0_im     = x_q[1];
  assign x1_re     = x_q[2];
  assign x1_im     = x_q[3];

endmodule
